dot_arbiter: RTL and testbench

Round-robin scheduler that shares a single fixed-point dot-product engine (`vecvec<N>`) among NUM_REQ requesters. It accepts one request at a time and latches that requester's operand vectors. It drives the engine's reset/start/complete handshake, then returns the result tagged with the requester index. It sits between the requesting datapath blocks and one `vecvec<N>` instance with matching DATA_WIDTH, BIN_POS and VECTOR_SIZE.

---
 rtl/dot_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_dot_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_arbiter.sv
// ============================================================================
// dot_arbiter : round-robin scheduler sharing one vecvec dot-product engine
//               among NUM_REQ requesters, one job in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dot_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int BIN_POS     = 16,
  parameter int VECTOR_SIZE = 4,
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT     = 1024,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int VW   = VECTOR_SIZE * DATA_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,          // active-low, synchronous
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*VW-1:0]      req_vec_a_i,
  input  logic [NUM_REQ*VW-1:0]      req_vec_b_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic                       busy_o,
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output logic [ID_W-1:0]            resp_id_o,
  output logic [DATA_WIDTH-1:0]      resp_dot_o,
  output logic                       resp_err_o,
  output logic                       eng_rst_o,
  input  logic                       eng_ready_i,
  input  logic                       eng_complete_i,
  output logic [VW-1:0]              eng_vec_a_o,
  output logic [VW-1:0]              eng_vec_b_o,
  input  logic [DATA_WIDTH-1:0]      eng_dot_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit CFG_OK = (NUM_REQ >= 2) && (TIMEOUT >= 1) &&
                          (BIN_POS >= 0) && (BIN_POS < DATA_WIDTH);

  // BIN_POS only matters to the engine; an unusable configuration adds no logic here.
  if (!CFG_OK) begin : g_cfg_invalid
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [ID_W-1:0]        resp_id_q, resp_id_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0]  resp_dot_q, resp_dot_d;
  logic                   eng_rst_q, eng_rst_d;
  logic [VW-1:0]          vec_a_q, vec_a_d;
  logic [VW-1:0]          vec_b_q, vec_b_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   hi_found, lo_found;
  logic [ID_W-1:0]        hi_idx, lo_idx, win_idx;
  logic [VW-1:0]          cap_a, cap_b;

  // Rotating priority: first requester at or above the pointer, else the lowest one.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hi_found && req_i[i] && (ID_W'(i) >= ptr_q)) begin
        hi_found = 1'b1;
        hi_idx   = ID_W'(i);
      end
      if (!lo_found && req_i[i]) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    cap_a = '0;
    cap_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        cap_a = req_vec_a_i[i*VW +: VW];
        cap_b = req_vec_b_i[i*VW +: VW];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = '0;
    ptr_d        = ptr_q;
    resp_id_d    = resp_id_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_dot_d   = resp_dot_q;
    eng_rst_d    = eng_rst_q;
    vec_a_d      = vec_a_q;
    vec_b_d      = vec_b_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          grant_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          resp_id_d = win_idx;
          vec_a_d   = cap_a;
          vec_b_d   = cap_b;
          ptr_d     = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        eng_rst_d = 1'b1;
        if (eng_ready_i) begin
          eng_rst_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        // Completion takes precedence over a timeout in the same cycle.
        if (eng_complete_i) begin
          resp_dot_d   = eng_dot_i;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          eng_rst_d    = 1'b1;
          state_d      = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          resp_dot_d   = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = 1'b1;
          eng_rst_d    = 1'b1;
          state_d      = S_DONE;
        end
      end

      S_DONE: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      ptr_q        <= '0;
      resp_id_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_dot_q   <= '0;
      eng_rst_q    <= 1'b1;
      vec_a_q      <= '0;
      vec_b_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      resp_id_q    <= resp_id_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_dot_q   <= resp_dot_d;
      eng_rst_q    <= eng_rst_d;
      vec_a_q      <= vec_a_d;
      vec_b_q      <= vec_b_d;
      cnt_q        <= cnt_d;
    end
  end

  assign grant_o      = grant_q;
  assign busy_o       = (state_q != S_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_id_o    = resp_id_q;
  assign resp_dot_o   = resp_dot_q;
  assign resp_err_o   = resp_err_q;
  assign eng_rst_o    = eng_rst_q;
  assign eng_vec_a_o  = vec_a_q;
  assign eng_vec_b_o  = vec_b_q;

endmodule

`default_nettype wire

// File: tb/tb_dot_arbiter.sv
// ============================================================================
// tb_dot_arbiter : self-checking bench for dot_arbiter with a latency-
//                  programmable engine model and a round-robin reference.
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dot_arbiter;

  localparam int NR = 4;
  localparam int VS = 4;
  localparam int DW = 32;
  localparam int VW = VS * DW;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*VW-1:0]  req_vec_a, req_vec_b;
  logic [NR-1:0]     grant;
  logic              busy, resp_valid, resp_ready, resp_err;
  logic [1:0]        resp_id;
  logic [DW-1:0]     resp_dot;
  logic              eng_rst, eng_ready, eng_complete;
  logic [VW-1:0]     eng_vec_a, eng_vec_b;
  logic [DW-1:0]     eng_dot;

  int n_vec = 0;
  int n_err = 0;
  int lat   = 5;
  int ecnt  = 0;

  logic [31:0] va [NR][VS];
  logic [31:0] vb [NR][VS];

  always #5 clk = ~clk;

  dot_arbiter #(
    .DATA_WIDTH(DW), .BIN_POS(16), .VECTOR_SIZE(VS), .NUM_REQ(NR), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req),
    .req_vec_a_i(req_vec_a), .req_vec_b_i(req_vec_b),
    .grant_o(grant), .busy_o(busy), .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready), .resp_id_o(resp_id), .resp_dot_o(resp_dot),
    .resp_err_o(resp_err), .eng_rst_o(eng_rst), .eng_ready_i(eng_ready),
    .eng_complete_i(eng_complete), .eng_vec_a_o(eng_vec_a),
    .eng_vec_b_o(eng_vec_b), .eng_dot_i(eng_dot)
  );

  // Q16 fixed-point dot product of two packed 4-element vectors
  function automatic logic [31:0] fx_dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
    longint acc = 0;
    for (int j = 0; j < VS; j++)
      acc += (longint'($signed(a[j*DW +: DW])) * longint'($signed(b[j*DW +: DW]))) >>> 16;
    return acc[31:0];
  endfunction

  // Engine model: idle/ready while held in reset, completes once its run count exceeds lat
  always @(posedge clk) begin
    if (eng_rst) ecnt <= 0;
    else         ecnt <= ecnt + 1;
  end
  assign eng_ready    = eng_rst;
  assign eng_complete = !eng_rst && (ecnt > lat);
  assign eng_dot      = fx_dot(eng_vec_a, eng_vec_b);

  function automatic logic [VW-1:0] pa(input int i);
    return {va[i][3], va[i][2], va[i][1], va[i][0]};
  endfunction
  function automatic logic [VW-1:0] pb(input int i);
    return {vb[i][3], vb[i][2], vb[i][1], vb[i][0]};
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < NR; i++) begin
      req_vec_a[i*VW +: VW] = pa(i);
      req_vec_b[i*VW +: VW] = pb(i);
    end
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < VS; j++) begin
        va[i][j] = $urandom;
        vb[i][j] = $urandom;
      end
    drive_ops();
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    resp_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // One complete job: grant, engine run, response, delayed acceptance.
  task automatic run_job(input logic [NR-1:0] mask, input int exp_id,
                         input logic [31:0] exp_dot, input logic exp_err,
                         input int exp_cyc, input int lt, input int rdly, input bit keep);
    int cyc;
    bit got;
    lat = lt;
    req = mask;
    step();
    cyc = 1;
    check("grant", grant, 4'b0001 << exp_id);
    check("grant_id", resp_id, exp_id);
    check("grant_busy", busy, 1);
    check("eng_vec_a", eng_vec_a, pa(exp_id));
    check("eng_vec_b", eng_vec_b, pb(exp_id));
    if (!keep) req = '0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      step();
      cyc++;
      if (resp_valid === 1'b1) got = 1'b1;
    end
    check("resp_cycle", got ? cyc : 0, exp_cyc);
    if (!got) return;
    check("resp_id", resp_id, exp_id);
    check("resp_dot", resp_dot, exp_dot);
    check("resp_err", resp_err, exp_err);
    if (!keep) req = 4'b1111;
    for (int h = 0; h < rdly; h++) begin
      step();
      check("hold_valid", resp_valid, 1);
      check("hold_dot", resp_dot, exp_dot);
      check("hold_id", resp_id, exp_id);
      check("hold_grant", grant, 0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    if (!keep) req = '0;
    check("accept_valid", resp_valid, 0);
    check("accept_busy", busy, 0);
  endtask

  typedef struct {
    logic [NR-1:0] req;
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    int            lat;
    logic [NR-1:0] exp_grant;
    logic [31:0]   exp_dot;
    logic          exp_err;
    int            exp_cyc;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int id;
    int rptr;
    int lt;
    bit seen;
    logic [NR-1:0] mask;

    // Jobs applied straight after reset, so the pointer starts at 0.
    tbl[0] = '{4'b0100, {32'h0, 32'h0, 32'h00020000, 32'h00010000},
               {32'h0, 32'h0, 32'h00008000, 32'h00030000}, 5, 4'b0100, 32'h00040000, 1'b0, 9};
    tbl[1] = '{4'b1011, {32'h00020000, 32'hFFFF0000, 32'h00004000, 32'h00008000},
               {32'h00010000, 32'h00010000, 32'h00040000, 32'h00020000}, 0, 4'b1000, 32'h00030000, 1'b0, 4};
    tbl[2] = '{4'b0110, {32'h0, 32'h0, 32'h0, 32'hFFFE0000},
               {32'h0, 32'h0, 32'h0, 32'h00018000}, 14, 4'b0010, 32'hFFFD0000, 1'b0, 18};
    tbl[3] = '{4'b0011, {4{32'h00010000}}, {4{32'h00010000}}, 15, 4'b0001, 32'h0, 1'b1, 18};
    tbl[4] = '{4'b1000, {32'h0, 32'h0, 32'h00008000, 32'h00008000},
               {32'h0, 32'h0, 32'h00008000, 32'h00008000}, 3, 4'b1000, 32'h00008000, 1'b0, 7};
    tbl[5] = '{4'b1111, {32'h0, 32'h0, 32'h0, 32'h00018000},
               {32'h0, 32'h0, 32'h0, 32'h00018000}, 1, 4'b0001, 32'h00024000, 1'b0, 5};
    tbl[6] = '{4'b1101, {32'h00010000, 32'h0, 32'h0, 32'h0},
               {32'h00010000, 32'h0, 32'h0, 32'h0}, 255, 4'b0100, 32'h0, 1'b1, 18};

    rst = 1'b0;
    req = 4'b1111;
    resp_ready = 1'b0;
    randomize_ops();

    // Reset held with every requester active
    for (int c = 0; c < 5; c++) begin
      step();
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", resp_valid, 0);
      check("rst_id", resp_id, 0);
      check("rst_dot", resp_dot, 0);
      check("rst_err", resp_err, 0);
      check("rst_eng_rst", eng_rst, 1);
      check("rst_vec_a", eng_vec_a, 0);
      check("rst_vec_b", eng_vec_b, 0);
    end
    req = '0;
    rst = 1'b1;
    step();

    // Table-driven jobs
    for (int k = 0; k < 7; k++) begin
      id = 0;
      for (int i = 0; i < NR; i++) if (tbl[k].exp_grant[i]) id = i;
      randomize_ops();
      for (int j = 0; j < VS; j++) begin
        va[id][j] = tbl[k].a[j*DW +: DW];
        vb[id][j] = tbl[k].b[j*DW +: DW];
      end
      drive_ops();
      run_job(tbl[k].req, id, tbl[k].exp_dot, tbl[k].exp_err, tbl[k].exp_cyc,
              tbl[k].lat, (k == 0) ? 10 : k % 3, 1'b0);
    end

    // Reset pulse while the engine is running
    randomize_ops();
    lat = 5;
    req = 4'b0100;
    step();
    check("rr_grant", grant, 4'b0100);
    req = '0;
    step();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midrst_eng_rst", eng_rst, 1);
    check("midrst_busy", busy, 0);
    check("midrst_valid", resp_valid, 0);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    check("midrst_no_resp", seen, 0);
    run_job(4'b1001, 0, fx_dot(pa(0), pb(0)), 1'b0, 9, 5, 0, 1'b0);

    // Continuously held requests rotate 0, 1, 3, 0
    do_reset();
    randomize_ops();
    run_job(4'b1011, 0, fx_dot(pa(0), pb(0)), 1'b0, 6, 2, 0, 1'b1);
    run_job(4'b1011, 1, fx_dot(pa(1), pb(1)), 1'b0, 6, 2, 1, 1'b1);
    run_job(4'b1011, 3, fx_dot(pa(3), pb(3)), 1'b0, 6, 2, 0, 1'b1);
    run_job(4'b1011, 0, fx_dot(pa(0), pb(0)), 1'b0, 6, 2, 2, 1'b1);
    req = '0;
    step();

    // Randomized jobs against a round-robin reference
    do_reset();
    rptr = 0;
    for (int n = 0; n < 40; n++) begin
      mask = 4'($urandom_range(1, 15));
      randomize_ops();
      id = -1;
      for (int off = 0; off < NR; off++)
        if (id < 0 && mask[(rptr + off) % NR]) id = (rptr + off) % NR;
      rptr = (id + 1) % NR;
      lt = $urandom_range(0, 20);
      if (lt > 16) lt = 255;
      if (lt > TO - 2)
        run_job(mask, id, 32'h0, 1'b1, 2 + TO, lt, $urandom_range(0, 3), 1'b0);
      else
        run_job(mask, id, fx_dot(pa(id), pb(id)), 1'b0, lt + 4, lt, $urandom_range(0, 3), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
